// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I pipeline types and constants for the fetch stage and IF/ID register.
// Revision: 1.0
`default_nettype none

package riscv_pkg;

  localparam int          IF_PC_W   = 9;
  localparam int          IF_INS_W  = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] HALT   = 7'b1111111;

  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [IF_PC_W-1:0]  pc;
    logic [IF_INS_W-1:0] instr;
    logic                valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

`default_nettype wire

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush-to-bubble (highest), load and hold.
// Revision: 1.0
`default_nettype none

module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load_i,
  input  logic   flush_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= IF_ID_BUBBLE;
    end else if (flush_i) begin
      q_q <= IF_ID_BUBBLE;
    end else if (load_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, halt FSM and fetch counter feeding IF/ID.
// Revision: 1.0
`default_nettype none

module fetch_stage
  import riscv_pkg::*;
#(
  parameter int              PC_W     = IF_PC_W,
  parameter int              INS_W    = IF_INS_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             halt_id,
  output logic [PC_W-1:0]  id_pc,
  output logic [INS_W-1:0] id_instr,
  output logic             id_valid,
  output logic             halted,
  output logic [31:0]      fetch_count
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     count_q, count_d;
  logic            halted_q;
  logic            load_d, flush_d;
  if_id_t          ifid_d, ifid_q;

  // Priority: halted > redirect > valid halt in ID > stall > sequential fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    load_d  = 1'b0;
    flush_d = 1'b0;
    if (state_q == FS_HALTED) begin
      flush_d = 1'b1;
    end else if (redirect) begin
      pc_d    = redirect_pc & ~PC_W'(3);
      flush_d = 1'b1;
    end else if (halt_id && ifid_q.valid) begin
      state_d = FS_HALTED;
      flush_d = 1'b1;
    end else if (!stall) begin
      pc_d    = pc_q + PC_W'(4);
      count_d = count_q + 32'd1;
      load_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FS_RUN;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      halted_q <= (state_d == FS_HALTED);
    end
  end

  assign ifid_d = '{pc: pc_q, instr: imem_rdata, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load_d),
    .flush_i (flush_d),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign imem_addr   = pc_q;
  assign id_pc       = ifid_q.pc;
  assign id_instr    = ifid_q.instr;
  assign id_valid    = ifid_q.valid;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a cycle-tagged expectation queue checked by a monitor.
// Revision: 1.0
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALTW = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        halt_id = 1'b0;
  logic [8:0]  id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        halted;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic [8:0]  idpc;
    logic [31:0] ins;
    logic        v;
    logic        h;
    logic [8:0]  pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] mem [0:127];

  fetch_stage #(.PC_W(9), .INS_W(32), .RESET_PC(9'h000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt_id     (halt_id),
    .id_pc       (id_pc),
    .id_instr    (id_instr),
    .id_valid    (id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign imem_rdata = mem[imem_addr[8:2]];

  // Distinct addi immediates make every word identify its own address.
  function automatic logic [31:0] ins_at(input logic [8:0] a);
    ins_at = {5'd0, a[8:2], 20'h00013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("tag_in_time", e.cyc, cyc);
      chk("id_valid", {31'd0, id_valid}, {31'd0, e.v});
      chk("id_instr", id_instr, e.ins);
      chk("halted", {31'd0, halted}, {31'd0, e.h});
      chk("imem_addr", {23'd0, imem_addr}, {23'd0, e.pc});
      chk("fetch_count", fetch_count, e.cnt);
      if (e.v) chk("id_pc", {23'd0, id_pc}, {23'd0, e.idpc});
    end
  end

  // Drive one cycle's inputs and record the state expected after the next edge.
  task automatic step(input logic st, input logic rd, input logic [8:0] rpc, input logic hl,
                      input logic [8:0] e_idpc, input logic [31:0] e_ins, input logic e_v,
                      input logic e_h, input logic [8:0] e_pc, input logic [31:0] e_cnt);
    exp_t e;
    stall = st; redirect = rd; redirect_pc = rpc; halt_id = hl;
    e.cyc = cyc + 1; e.idpc = e_idpc; e.ins = e_ins; e.v = e_v;
    e.h = e_h; e.pc = e_pc; e.cnt = e_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 128; k++) mem[k] = ins_at(9'(k * 4));
    mem[48] = HALTW;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", {23'd0, imem_addr}, 32'h0);
    chk("rst_valid", {31'd0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_halted", {31'd0, halted}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
    reset = 1'b0;

    // sequential fetch, then a two-cycle stall with pc=8
    step(0, 0, 9'h000, 0, 9'h000, ins_at(9'h000), 1, 0, 9'h004, 1);
    step(0, 0, 9'h000, 0, 9'h004, ins_at(9'h004), 1, 0, 9'h008, 2);
    step(1, 0, 9'h000, 0, 9'h004, ins_at(9'h004), 1, 0, 9'h008, 2);
    step(1, 0, 9'h000, 0, 9'h004, ins_at(9'h004), 1, 0, 9'h008, 2);
    step(0, 0, 9'h000, 0, 9'h008, ins_at(9'h008), 1, 0, 9'h00C, 3);
    // redirect with misaligned target beats a simultaneous stall
    step(1, 1, 9'h043, 0, 9'h000, NOP, 0, 0, 9'h040, 3);
    step(0, 0, 9'h000, 0, 9'h040, ins_at(9'h040), 1, 0, 9'h044, 4);
    // redirect beats halt in the same cycle
    step(0, 1, 9'h080, 1, 9'h000, NOP, 0, 0, 9'h080, 4);
    step(0, 0, 9'h000, 0, 9'h080, ins_at(9'h080), 1, 0, 9'h084, 5);
    // halt on a bubble is ignored
    step(0, 1, 9'h100, 0, 9'h000, NOP, 0, 0, 9'h100, 5);
    step(0, 0, 9'h000, 1, 9'h100, ins_at(9'h100), 1, 0, 9'h104, 6);
    // PC wraps from 0x1FC to 0x000
    step(0, 1, 9'h1F8, 0, 9'h000, NOP, 0, 0, 9'h1F8, 6);
    step(0, 0, 9'h000, 0, 9'h1F8, ins_at(9'h1F8), 1, 0, 9'h1FC, 7);
    step(0, 0, 9'h000, 0, 9'h1FC, ins_at(9'h1FC), 1, 0, 9'h000, 8);
    step(0, 0, 9'h000, 0, 9'h000, ins_at(9'h000), 1, 0, 9'h004, 9);
    // HALT word at 0xC0 reaches IF/ID, then decode asserts halt
    step(0, 1, 9'h0C0, 0, 9'h000, NOP, 0, 0, 9'h0C0, 9);
    step(0, 0, 9'h000, 0, 9'h0C0, HALTW, 1, 0, 9'h0C4, 10);
    step(0, 0, 9'h000, 1, 9'h000, NOP, 0, 1, 9'h0C4, 10);
    for (int i = 0; i < 10; i++) begin
      step(i[0], i[1], 9'h020, i[2], 9'h000, NOP, 0, 1, 9'h0C4, 10);
    end

    // asynchronous reset while halted takes effect without a clock edge
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_halted", {31'd0, halted}, 32'h0);
    chk("arst_pc", {23'd0, imem_addr}, 32'h0);
    chk("arst_valid", {31'd0, id_valid}, 32'h0);
    chk("arst_count", fetch_count, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 0, 9'h000, 0, 9'h000, ins_at(9'h000), 1, 0, 9'h004, 1);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
